regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between NUM_SRC writeback sources (e.g. ALU, load unit, CSR/mul-div), each with valid/ready handshake.
Each source has a 1-entry holding buffer. A round-robin arbiter drains the buffers into a registered write port that drives the register file directly.
A busy-bit scoreboard tracks destinations with pending writes and flags RAW hazards for the decode stage.

Parameters:
NUM_SRC, 2, number of writeback requesters (legal 2..4)
XLEN, 32, data width
REG_ADDR_W, 5, register address width (32 registers)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
src_valid_i  input  NUM_SRC  source i has a writeback
src_ready_o  output  NUM_SRC  source i transfer accepted when valid&ready at clk edge
src_rd_i  input  NUM_SRC*REG_ADDR_W  destination register per source, source i at slice i
src_data_i  input  NUM_SRC*XLEN  write data per source
issue_valid_i  input  1  decode issues an instruction that will write issue_rd_i
issue_rd_i  input  REG_ADDR_W  destination being reserved
rs1_addr_i, rs2_addr_i  input  REG_ADDR_W each  decode source operands to check
hazard_o  output  1  rs1 or rs2 has a pending write; decode must stall
busy_o  output  2**REG_ADDR_W  scoreboard bitmap, debug/visibility
rf_wr_en_o  output  1  register file write enable
rf_rd_addr_o  output  REG_ADDR_W  register file write address
rf_data_o  output  XLEN  register file write data

Behaviour:
- Reset (async, rst_n=0): all hold buffers invalid, busy_o=0, RR pointer=0, rf_wr_en_o=0, rf_rd_addr_o=0, rf_data_o=0. Any in-flight writeback is dropped. src_ready_o=all 1 while hold buffers are empty.
- src_ready_o[i] = ~hold_valid[i] | grant[i]. Depends only on internal state; there is no combinational path from src_valid_i to src_ready_o.
- Accept: on valid&ready, hold[i] <= {rd, data}, hold_valid[i] <= 1. A simultaneous grant and new accept on the same source is a full-throughput refill.
- Arbitration, combinational: among hold_valid, grant the first index at or after rr_ptr, wrapping modulo NUM_SRC. At most one grant per cycle.
- rr_ptr <= granted index + 1 (mod NUM_SRC) on a grant; unchanged otherwise.
- Write port registered: on grant, rf_rd_addr_o/rf_data_o <= hold[g]. rf_wr_en_o <= 1 if rd != 0, else 0; a write to x0 is consumed silently.
- No grant: rf_wr_en_o <= 0; addr/data hold their last values.
- Latency, uncontended: accept at edge T, rf_wr_en_o high in cycle T+1..T+2, i.e. for one cycle starting at edge T+1. The register file captures at the next edge.
- Throughput: one write per cycle total. Each source is starved at most NUM_SRC-1 grants.
- Scoreboard: busy[r] cleared when rf_wr_en_o=1 with rf_rd_addr_o=r (the cycle the write is presented). busy[r] set on issue_valid_i with issue_rd_i=r.
- Same-cycle set and clear of the same r: set wins.
- issue_rd_i=0 is ignored; busy[0] is always 0.
- Issuing to an already-busy r is legal; the bit stays set and clears on the next write to r. The decode stage must not issue a second writer to a busy rd.
- hazard_o = (busy[rs1] & rs1!=0) | (busy[rs2] & rs2!=0), combinational.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: adds outputs rs1_fwd_o, rs2_fwd_o (1 each) and fwd_data_o (XLEN) = rf_data_o.
  - rsN_fwd_o = rf_wr_en_o & rf_rd_addr_o==rsN & rsN!=0.
  - The hazard term for rsN is masked when rsN_fwd_o=1, so decode consumes the forwarded value one cycle earlier.
- Undefined: those ports are absent and hazard_o is exactly as above.

Decomposition:
- Package regfile_pkg: XLEN, REG_ADDR_W, NUM_REGS constants; packed struct wb_req_t {rd, data}.
- One sub-module: rr_arbiter (NUM_SRC request vector + pointer -> one-hot grant, plus next pointer), reusable elsewhere.

Test Plan:
- Single write: src0 valid rd=5 data=0xDEADBEEF at edge T -> rf_wr_en_o=1, addr=5, data=0xDEADBEEF for one cycle after edge T+1; src_ready_o stays 1.
- Contention: src0 (rd=1, 0x11) and src1 (rd=2, 0x22) accepted the same edge, rr_ptr=0 -> writes rd=1 then rd=2 on consecutive cycles. Repeated streams alternate 0,1,0,1.
- Back-pressure: src1 streams continuously while src0 holds a request -> src1_ready_o=0 for exactly one cycle per lost grant; no data lost or duplicated (scoreboard-checked sequence).
- Scoreboard: issue rd=7, then rs1=7 -> hazard_o=1 until the rd=7 write presents, then 0 next cycle. Same-cycle issue rd=7 and write rd=7 -> busy[7] stays 1.
- x0: write rd=0 data=0xFFFF -> rf_wr_en_o stays 0, src accepted. Issue rd=0 -> busy_o[0]=0, hazard_o=0 for rs1=0.
- Reset mid-stream: rst_n low while both holds valid and busy=0x0000_00F0 -> outputs zero immediately (async). After release, no stale write appears.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback path.
// Pure declarations; no logic or latency.
// No flow control lives here.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr_i, wrapping modulo N.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to advance the pointer to next_ptr_o.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          gnt_vld_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic [PW-1:0] next_ptr_o
);

  // Scan from the pointer forward and take the first requester found.
  always_comb begin
    int idx;
    idx        = 0;
    gnt_o      = '0;
    gnt_vld_o  = 1'b0;
    gnt_idx_o  = '0;
    next_ptr_o = ptr_i;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= N) idx = idx - N;
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_vld_o  = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = PW'(idx);
        next_ptr_o = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port among NUM_SRC writeback sources; busy-bit scoreboard for RAW stalls.
// Latency: accept at edge T, write presented on rf_* from edge T+1 for one cycle.
// Backpressure: src_ready_o[i] low only while source i holds a buffered request that lost arbitration.
// Optional WB_BYPASS_EN adds rs1_fwd_o/rs2_fwd_o/fwd_data_o and masks the forwarded hazard terms.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_valid_i,
  output logic [NUM_SRC-1:0]            src_ready_o,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_rd_i,
  input  logic [NUM_SRC*XLEN-1:0]       src_data_i,
  input  logic                          issue_valid_i,
  input  logic [REG_ADDR_W-1:0]         issue_rd_i,
  input  logic [REG_ADDR_W-1:0]         rs1_addr_i,
  input  logic [REG_ADDR_W-1:0]         rs2_addr_i,
  output logic                          hazard_o,
`ifdef WB_BYPASS_EN
  output logic                          rs1_fwd_o,
  output logic                          rs2_fwd_o,
  output logic [XLEN-1:0]               fwd_data_o,
`endif
  output logic [NUM_REGS-1:0]           busy_o,
  output logic                          rf_wr_en_o,
  output logic [REG_ADDR_W-1:0]         rf_rd_addr_o,
  output logic [XLEN-1:0]               rf_data_o
);

  localparam int PW = $clog2(NUM_SRC);

  wb_req_t              hold_q [NUM_SRC];
  wb_req_t              hold_d [NUM_SRC];
  logic [NUM_SRC-1:0]   hold_vld_q, hold_vld_d;
  logic [NUM_SRC-1:0]   gnt, accept;
  logic                 gnt_vld;
  logic [PW-1:0]        gnt_idx, rr_next, rr_ptr_q, rr_ptr_d;
  wb_req_t              gnt_req;
  logic                 wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]      wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic                 rs1_fwd, rs2_fwd;

  rr_arbiter #(.N(NUM_SRC), .PW(PW)) u_rr (
    .req_i      (hold_vld_q),
    .ptr_i      (rr_ptr_q),
    .gnt_o      (gnt),
    .gnt_vld_o  (gnt_vld),
    .gnt_idx_o  (gnt_idx),
    .next_ptr_o (rr_next)
  );

  // A buffer being drained this cycle can take a new request: full-rate refill.
  assign src_ready_o = ~hold_vld_q | gnt;
  assign accept      = src_valid_i & src_ready_o;
  assign gnt_req     = hold_q[gnt_idx];

  // Hold buffers: drain on grant, load on accept (load wins on same-cycle refill).
  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) hold_vld_d[i] = 1'b0;
      if (accept[i]) begin
        hold_vld_d[i]     = 1'b1;
        hold_d[i].rd      = src_rd_i[i*REG_ADDR_W +: REG_ADDR_W];
        hold_d[i].data    = src_data_i[i*XLEN +: XLEN];
      end
    end
  end

  // Pointer advances past the winner so every source waits at most NUM_SRC-1 grants.
  always_comb begin
    rr_ptr_d = gnt_vld ? rr_next : rr_ptr_q;
  end

  // Registered write port; a write to x0 is consumed with the enable held low.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (gnt_vld) begin
      wr_en_d   = |gnt_req.rd;
      wr_addr_d = gnt_req.rd;
      wr_data_d = gnt_req.data;
    end
  end

  // Scoreboard: clear on the presented write, then set on issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) busy_d[wr_addr_q] = 1'b0;
    if (issue_valid_i && (|issue_rd_i)) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers; reset drops any in-flight writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) hold_q[i] <= '0;
      hold_vld_q <= '0;
      rr_ptr_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

`ifdef WB_BYPASS_EN
  // A write presented this cycle to an operand can be forwarded instead of stalling.
  assign rs1_fwd    = wr_en_q && (wr_addr_q == rs1_addr_i) && (|rs1_addr_i);
  assign rs2_fwd    = wr_en_q && (wr_addr_q == rs2_addr_i) && (|rs2_addr_i);
  assign rs1_fwd_o  = rs1_fwd;
  assign rs2_fwd_o  = rs2_fwd;
  assign fwd_data_o = wr_data_q;
`else
  assign rs1_fwd = 1'b0;
  assign rs2_fwd = 1'b0;
`endif

  assign hazard_o = (busy_q[rs1_addr_i] && (|rs1_addr_i) && !rs1_fwd) ||
                    (busy_q[rs2_addr_i] && (|rs2_addr_i) && !rs2_fwd);

  assign busy_o       = busy_q;
  assign rf_wr_en_o   = wr_en_q;
  assign rf_rd_addr_o = wr_addr_q;
  assign rf_data_o    = wr_data_q;

endmodule
